pw_multi_pattern_matcher: RTL
=============================

// Module: pw_multi_pattern_matcher
// PURPOSE
//  Next-generation frontend pattern matcher: pCHANNELS independent masked patterns, each up
//  to pMAX_BYTES long, compared against a sliding window of the last pMAX_BYTES valid frontend
//  bytes. No byte-level restart bug: every alignment is tested. First match wins, is latched
//  until capture ends or disarm, and drives the capture and trigger blocks by per-channel action.
// PARAMETERS
//  pCHANNELS    2   number of pattern channels (1..8)
//  pMAX_BYTES   16  window depth / max pattern length in bytes (1..64)
//  pCH_BITS     3   width of O_match_id, >= clog2(pCHANNELS), min 1
// PORTS
//  fe_clk           in   1                    sole clock
//  reset_i          in   1                    synchronous, active-high reset
//  I_arm            in   1                    level; 1=armed, 0=disarmed (already fe_clk-domain)
//  I_pattern        in   pCHANNELS*pMAX_BYTES*8  ch c byte i at [(c*pMAX_BYTES+i)*8 +: 8]; byte 0 first on wire
//  I_mask           in   pCHANNELS*pMAX_BYTES*8  same layout; 1=compare bit
//  I_pattern_bytes  in   pCHANNELS*8          ch c length at [c*8 +: 8]; 0=channel disabled
//  I_action         in   pCHANNELS*2          ch c at [c*2 +: 2]; 0=none,1=trigger,2=capture,3=both
//  I_fe_data        in   8                    frontend byte
//  I_fe_data_valid  in   1                    I_fe_data valid this cycle
//  I_capturing      in   1                    capture block busy
//  O_match          out  pCHANNELS            latched one-hot of winning channel
//  O_match_id       out  pCH_BITS             index of winning channel
//  O_match_capture  out  1                    level: match latched and winner action bit1
//  O_match_trigger  out  1                    one-cycle pulse on latch if winner action bit0
//  O_state          out  2                    FSM state for register readback
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, window and fill count cleared.
//  FSM: IDLE(0) --I_arm=1--> HUNT(1) --any channel hit--> MATCHED(2)
//       MATCHED --falling edge of I_capturing--> HUNT (window/fill cleared) if I_arm still 1
//       any state --I_arm=0--> IDLE, clears window, fill, O_match, O_match_id next cycle.
//  Window: in HUNT only, on I_fe_data_valid shift in byte; win[0]=newest. fill counter
//   saturates at pMAX_BYTES. Bytes in IDLE/MATCHED are ignored (not shifted).
//  Length L_c = min(I_pattern_bytes[c], pMAX_BYTES). Channel c hits when L_c!=0, fill>=L_c and
//   for all i<L_c: (win[L_c-1-i] ^ pattern[c][i]) & mask[c][i] == 0. Mask all-0 over L_c
//   matches as soon as fill>=L_c.
//  Pipeline: compare on window register, hit registered; O_match/O_match_id/O_match_capture
//   valid on 2nd fe_clk edge after the edge that samples the final pattern byte; O_match_trigger
//   high that same single cycle. Hit pipeline discarded if FSM leaves HUNT meanwhile.
//  Simultaneous hits: lowest channel index wins; only one bit of O_match ever set.
//  Capture end and I_arm=0 same cycle: IDLE wins. Capture end with no latched match: no effect.
//  Config inputs treated static while armed; changes while armed take effect next compare.
//  Width rules: fill is clog2(pMAX_BYTES+1) bits, saturating; I_pattern_bytes>pMAX clamped.
// CONFIGURATION
//  PM_MATCH_COUNT_EN defined: adds output O_match_count [15:0]: count of latched matches since
//   last reset_i or IDLE entry, +1 per MATCHED entry, saturates at 16'hFFFF.
//  Undefined: port absent, no counter logic; all other behaviour identical.
// TESTING
//  1 Reset: reset_i=1 3 cycles mid-HUNT with fill=5 -> all outputs 0, O_state=0, fill=0.
//  2 Overlap: ch0 pattern 41 41 42 len3 mask FF, action=1; bytes 41 41 41 42 -> O_match=01,
//    O_match_id=0, O_match_trigger 1-cycle pulse 2 edges after byte 42; capture low.
//  3 Priority+mask: ch0 AA 55 mask FF 00 len2, ch1 AA 55 mask FF FF len2 action=2; bytes AA 55
//    -> O_match=01 only; retry with ch0 len0 -> O_match=10, O_match_capture=1.
//  4 Gaps/fill: ch0 len4 = 01 02 03 04; bytes with valid gaps of 3 idle cycles -> single match;
//    arm then send only 02 03 04 -> no match (fill<4 rule not required; pattern absent).
//  5 Release: match latched, I_capturing 1->0 -> O_state=1, O_match=0, new pattern re-matches;
//    same cycle I_arm=0 -> O_state=0.
//  6 Bounds: pMAX_BYTES=16, len=200 -> treated as 16; 16-byte pattern matches full window;
//    with PM_MATCH_COUNT_EN, 3 release/rematch cycles -> O_match_count=3.

Source files
------------

// File: rtl/pw_multi_pattern_matcher.sv
// -----------------------------------------------------------------------------
// pw_multi_pattern_matcher
//
// Purpose:
//   Frontend pattern matcher. Each of pCHANNELS channels holds a masked pattern
//   of up to pMAX_BYTES bytes. The channel is compared against a sliding window
//   of the most recent valid frontend bytes at every alignment. The first hit
//   is latched until the capture block finishes or the matcher is disarmed. The
//   winning channel's action selects a capture level and/or a trigger pulse.
//
// Ports:
//   fe_clk           sole clock
//   reset_i          synchronous active-high reset
//   I_arm            level: 1 = armed, 0 = disarmed
//   I_pattern        ch c byte i at [(c*pMAX_BYTES+i)*8 +: 8]; byte 0 is the oldest
//   I_mask           same layout as I_pattern; a 1 bit takes part in the compare
//   I_pattern_bytes  ch c length at [c*8 +: 8]; 0 disables the channel
//   I_action         ch c at [c*2 +: 2]; bit0 = trigger, bit1 = capture
//   I_fe_data        frontend byte
//   I_fe_data_valid  I_fe_data is valid this cycle
//   I_capturing      capture block busy; its falling edge releases a match
//   O_match          one-hot of the latched winning channel
//   O_match_id       index of the latched winning channel
//   O_match_capture  level: a match is latched and the winner has action bit1
//   O_match_trigger  one-cycle pulse on latch when the winner has action bit0
//   O_state          FSM state (0 = IDLE, 1 = HUNT, 2 = MATCHED)
//   O_match_count    present only when PM_MATCH_COUNT_EN is defined: count of
//                    latched matches since reset or IDLE entry, saturating
//
// Build option: PM_MATCH_COUNT_EN adds O_match_count and its counter.
// -----------------------------------------------------------------------------
module pw_multi_pattern_matcher #(
    parameter int pCHANNELS  = 2,
    parameter int pMAX_BYTES = 16,
    parameter int pCH_BITS   = 3
) (
    input  logic                              fe_clk,
    input  logic                              reset_i,
    input  logic                              I_arm,
    input  logic [pCHANNELS*pMAX_BYTES*8-1:0] I_pattern,
    input  logic [pCHANNELS*pMAX_BYTES*8-1:0] I_mask,
    input  logic [pCHANNELS*8-1:0]            I_pattern_bytes,
    input  logic [pCHANNELS*2-1:0]            I_action,
    input  logic [7:0]                        I_fe_data,
    input  logic                              I_fe_data_valid,
    input  logic                              I_capturing,
    output logic [pCHANNELS-1:0]              O_match,
    output logic [pCH_BITS-1:0]               O_match_id,
    output logic                              O_match_capture,
    output logic                              O_match_trigger,
    output logic [1:0]                        O_state
`ifdef PM_MATCH_COUNT_EN
    ,
    output logic [15:0]                       O_match_count
`endif
);

    localparam int FILL_W = $clog2(pMAX_BYTES + 1);
    localparam int WIN_W  = pMAX_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_MATCHED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIN_W-1:0]       r_win;          // byte k at [k*8 +: 8], byte 0 newest
    logic [WIN_W-1:0]       w_win_shift;
    logic [FILL_W-1:0]      r_fill;
    logic [pCHANNELS-1:0]   w_hit;
    logic [pCHANNELS-1:0]   r_hit;
    logic [pCHANNELS-1:0]   w_first;
    logic [pCHANNELS-1:0]   r_match;
    logic [pCH_BITS-1:0]    r_match_id;
    logic                   r_capture;
    logic                   r_trigger;
    logic                   r_cap_q;
    logic                   w_cap_fall;
    logic                   w_hunt_stay;
    logic                   w_latch;
    logic                   w_release;
    logic [pCH_BITS-1:0]    w_win_id;
    logic [1:0]             w_win_act;
    logic [pCH_BITS-1:0][pCHANNELS-1:0] w_id_bits;
    logic [1:0][pCHANNELS-1:0]          w_act_bits;

    assign w_cap_fall  = r_cap_q & ~I_capturing;
    assign w_hunt_stay = (r_state == ST_HUNT) && (w_state_next == ST_HUNT);
    assign w_latch     = (r_state == ST_HUNT) && (w_state_next == ST_MATCHED);
    assign w_release   = (r_state == ST_MATCHED) && (w_state_next == ST_HUNT);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_cap_q <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cap_q <= I_capturing;
        end
    end

    // Disarm is checked first in every state so that it beats a capture end
    // arriving in the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (I_arm) w_state_next = ST_HUNT;
            ST_HUNT:    if (!I_arm) w_state_next = ST_IDLE;
                        else if (|r_hit) w_state_next = ST_MATCHED;
            ST_MATCHED: if (!I_arm) w_state_next = ST_IDLE;
                        else if (w_cap_fall) w_state_next = ST_HUNT;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- window
    generate
        if (pMAX_BYTES == 1) begin : g_shift_one
            assign w_win_shift = I_fe_data;
        end else begin : g_shift_many
            assign w_win_shift = {r_win[WIN_W-9:0], I_fe_data};
        end
    endgenerate

    // The window only lives while hunting; any exit (or the release back into
    // HUNT) starts the next hunt from an empty window.
    always_ff @(posedge fe_clk) begin
        if (reset_i || !w_hunt_stay) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (I_fe_data_valid) begin
            r_win <= w_win_shift;
            if (r_fill != FILL_W'(pMAX_BYTES)) r_fill <= r_fill + FILL_W'(1);
        end
    end

    // ---------------------------------------------------------------- compare
    // One fully unrolled comparator per possible length; the clamped length
    // selects which one counts. Pattern byte i lines up with window byte L-1-i.
    genvar gi, gl, gb;
    generate
        for (gi = 0; gi < pCHANNELS; gi++) begin : g_ch
            logic [7:0]            w_len_raw;
            logic [7:0]            w_len;
            logic [pMAX_BYTES-1:0] w_sel;

            assign w_len_raw = I_pattern_bytes[gi*8 +: 8];
            assign w_len     = (w_len_raw > 8'(pMAX_BYTES)) ? 8'(pMAX_BYTES) : w_len_raw;

            for (gl = 1; gl <= pMAX_BYTES; gl++) begin : g_len
                logic [gl-1:0] w_byte_ok;
                for (gb = 0; gb < gl; gb++) begin : g_byte
                    assign w_byte_ok[gb] =
                        ((r_win[(gl-1-gb)*8 +: 8] ^ I_pattern[(gi*pMAX_BYTES+gb)*8 +: 8])
                         & I_mask[(gi*pMAX_BYTES+gb)*8 +: 8]) == 8'd0;
                end
                assign w_sel[gl-1] = (w_len == 8'(gl)) && (r_fill >= FILL_W'(gl)) && (&w_byte_ok);
            end
            assign w_hit[gi] = |w_sel;

            // Lowest-index hit wins.
            if (gi == 0) begin : g_first0
                assign w_first[gi] = r_hit[gi];
            end else begin : g_firstn
                assign w_first[gi] = r_hit[gi] & ~(|r_hit[gi-1:0]);
            end

            for (gb = 0; gb < pCH_BITS; gb++) begin : g_idbit
                assign w_id_bits[gb][gi] = w_first[gi] & (((gi >> gb) & 1) == 1);
            end
            assign w_act_bits[0][gi] = w_first[gi] & I_action[gi*2];
            assign w_act_bits[1][gi] = w_first[gi] & I_action[gi*2+1];
        end

        for (gb = 0; gb < pCH_BITS; gb++) begin : g_id
            assign w_win_id[gb] = |w_id_bits[gb];
        end
    endgenerate

    assign w_win_act = {|w_act_bits[1], |w_act_bits[0]};

    // Hits from a window that is about to be abandoned are dropped.
    always_ff @(posedge fe_clk) begin
        if (reset_i || !w_hunt_stay) r_hit <= '0;
        else                         r_hit <= w_hit;
    end

    // ---------------------------------------------------------------- outputs
    always_ff @(posedge fe_clk) begin
        if (reset_i || !I_arm) begin
            r_match    <= '0;
            r_match_id <= '0;
            r_capture  <= 1'b0;
            r_trigger  <= 1'b0;
        end else begin
            r_trigger <= 1'b0;
            if (w_latch) begin
                r_match    <= w_first;
                r_match_id <= w_win_id;
                r_capture  <= w_win_act[1];
                r_trigger  <= w_win_act[0];
            end else if (w_release) begin
                r_match    <= '0;
                r_match_id <= '0;
                r_capture  <= 1'b0;
            end
        end
    end

`ifdef PM_MATCH_COUNT_EN
    logic [15:0] r_match_count;
    always_ff @(posedge fe_clk) begin
        if (reset_i || !I_arm)                          r_match_count <= '0;
        else if (w_latch && (r_match_count != 16'hFFFF)) r_match_count <= r_match_count + 16'd1;
    end
    assign O_match_count = r_match_count;
`endif

    assign O_match         = r_match;
    assign O_match_id      = r_match_id;
    assign O_match_capture = r_capture;
    assign O_match_trigger = r_trigger;
    assign O_state         = r_state;

endmodule
